// File: rtl/mem_access_unit.sv
// Memory access stage for a multicycle CPU: turns controller strobes into a
// req/ack bus transaction, captures IR/MDR and stalls the controller meanwhile.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              stall,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ir_pend;
  logic             start;
  logic             timeout_hit;

  assign start       = (state == IDLE) && (mem_read || mem_write);
  // The last waiting cycle is the one in which the counter still reads TIMEOUT-1.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign bus_req     = (state == REQ);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves a value held, which would infer a latch.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ir_out    <= '0;
      mdr_out   <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      ir_pend   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start) begin
        bus_addr  <= ior_d ? alu_out : pc;
        bus_wdata <= wr_data;
        bus_we    <= mem_write;
        ir_pend   <= ir_write;
        cnt       <= '0;
        // Conflicting strobes: the write wins, but the controller bug is flagged.
        if (mem_read && mem_write) err <= 1'b1;
      end

      if (state == REQ) begin
        if (bus_ack) begin
          if (!bus_we) begin
            mdr_out <= bus_rdata;
            if (ir_pend) ir_out <= bus_rdata;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) err <= 1'b1;
        end
      end else if (bus_ack) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model driven
// alongside directed and randomized accesses, compared on every falling edge.
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write, ior_d, ir_write;
  logic [AW-1:0] pc, alu_out;
  logic [DW-1:0] wr_data;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic [DW-1:0] ir_out, mdr_out;
  logic          stall, err;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .ior_d(ior_d), .ir_write(ir_write),
    .pc(pc), .alu_out(alu_out), .wr_data(wr_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ir_out(ir_out), .mdr_out(mdr_out), .stall(stall), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural view of the unit: what the registers hold right now.
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ir, m_mdr;
  logic          m_we, m_err;

  // Expected outputs for the current cycle.
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_ir, exp_mdr;
  logic          exp_we, exp_err, exp_stall, exp_req;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_ir = '0; m_mdr = '0; m_we = 1'b0; m_err = 1'b0;
  endtask

  task automatic set_exp(input bit st, input bit rq);
    exp_stall = st;     exp_req = rq;
    exp_addr  = m_addr; exp_we  = m_we; exp_wdata = m_wdata;
    exp_ir    = m_ir;   exp_mdr = m_mdr; exp_err  = m_err;
  endtask

  task automatic drive_junk();
    pc        = $urandom;
    alu_out   = $urandom;
    wr_data   = $urandom;
    bus_rdata = $urandom;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",     {31'd0, stall},   {31'd0, exp_stall});
      check("bus_req",   {31'd0, bus_req}, {31'd0, exp_req});
      check("bus_we",    {31'd0, bus_we},  {31'd0, exp_we});
      check("err",       {31'd0, err},     {31'd0, exp_err});
      check("bus_addr",  bus_addr,  exp_addr);
      check("bus_wdata", bus_wdata, exp_wdata);
      check("ir_out",    ir_out,    exp_ir);
      check("mdr_out",   mdr_out,   exp_mdr);
    end
  end

  // One memory access. ack_at = REQ cycle carrying bus_ack (0 = never, forcing a
  // timeout); abort_at = REQ cycle in which reset is pulsed (0 = none).
  task automatic access(input bit rd, input bit wr, input bit iord, input bit irw,
                        input logic [AW-1:0] pcv, input logic [AW-1:0] aluv,
                        input logic [DW-1:0] wdv, input int ack_at,
                        input logic [DW-1:0] rdv, input int abort_at);
    int n_req;
    mem_read = rd; mem_write = wr; ior_d = iord; ir_write = irw;
    pc = pcv; alu_out = aluv; wr_data = wdv; bus_ack = 1'b0; bus_rdata = $urandom;
    set_exp(1'b1, 1'b0);
    step();
    m_addr  = iord ? aluv : pcv;
    m_we    = wr;
    m_wdata = wdv;
    if (rd && wr) m_err = 1'b1;
    n_req = (ack_at == 0) ? TO : ack_at;
    for (int c = 1; c <= n_req; c++) begin
      // Controller-side inputs are don't-care while the request is in flight.
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      ior_d    = 1'($urandom); ir_write  = 1'($urandom);
      drive_junk();
      bus_ack = (c == ack_at);
      if (c == ack_at) bus_rdata = rdv;
      set_exp(1'b1, 1'b1);
      if (c == abort_at) begin
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_bus_req",   {31'd0, bus_req}, 32'd0);
        check("rst_stall",     {31'd0, stall},   32'd0);
        check("rst_bus_we",    {31'd0, bus_we},  32'd0);
        check("rst_bus_addr",  bus_addr,  32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_ir",        ir_out,    32'd0);
        check("rst_mdr",       mdr_out,   32'd0);
        check("rst_err",       {31'd0, err},     32'd0);
        model_reset();
        set_exp(1'b0, 1'b0);
        step();
        rst = 1'b1;
        return;
      end
      step();
    end
    if (ack_at != 0 && !wr) begin
      m_mdr = rdv;
      if (irw) m_ir = rdv;
    end
    if (ack_at == 0) m_err = 1'b1;
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    ior_d    = 1'($urandom); ir_write  = 1'($urandom);
    drive_junk();
    bus_ack = 1'b0;
    set_exp(1'b0, 1'b0);
    step();
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    set_exp(1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      mem_read = 1'b0; mem_write = 1'b0; bus_ack = stray;
      drive_junk();
      set_exp(1'b0, 1'b0);
      step();
      if (stray) m_err = 1'b1;
    end
    bus_ack = 1'b0;
    set_exp(1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    rst = 1'b0;
    model_reset();
    set_exp(1'b0, 1'b0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; ior_d = 1'b0; ir_write = 1'b0;
    pc = '0; alu_out = '0; wr_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    model_reset();
    set_exp(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus_req", {31'd0, bus_req}, 32'd0);
    check("reset_stall",   {31'd0, stall},   32'd0);
    check("reset_err",     {31'd0, err},     32'd0);
    check("reset_ir",      ir_out,  32'd0);
    check("reset_mdr",     mdr_out, 32'd0);
    check("reset_addr",    bus_addr, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    step();

    // Instruction fetch, minimum latency.
    access(1, 0, 0, 1, 32'h40, $urandom, $urandom, 1, 32'h2008_0005, 0);
    check("fetch_ir",   ir_out,   32'h2008_0005);
    check("fetch_mdr",  mdr_out,  32'h2008_0005);
    check("fetch_addr", bus_addr, 32'h40);
    check("fetch_we",   {31'd0, bus_we}, 32'd0);

    // Data load, ack after five wait cycles.
    access(1, 0, 1, 0, $urandom, 32'h100, $urandom, 6, 32'hDEAD_BEEF, 0);
    check("load_mdr",  mdr_out,  32'hDEAD_BEEF);
    check("load_ir",   ir_out,   32'h2008_0005);
    check("load_addr", bus_addr, 32'h100);

    // Store.
    access(0, 1, 1, 0, $urandom, 32'h204, 32'h1234, 3, $urandom, 0);
    check("store_we",    {31'd0, bus_we}, 32'd1);
    check("store_addr",  bus_addr,  32'h204);
    check("store_wdata", bus_wdata, 32'h1234);
    check("store_mdr",   mdr_out,   32'hDEAD_BEEF);
    check("store_err",   {31'd0, err}, 32'd0);

    // Reset during REQ, then a clean fetch.
    access(1, 0, 0, 1, 32'h80, $urandom, $urandom, 5, 32'h1111_1111, 2);
    access(1, 0, 0, 1, 32'h80, $urandom, $urandom, 2, 32'hCAFE_F00D, 0);
    check("post_rst_ir",  ir_out, 32'hCAFE_F00D);
    check("post_rst_err", {31'd0, err}, 32'd0);

    // Timeout, then a normal access with err still sticky.
    access(1, 0, 1, 0, $urandom, 32'h300, $urandom, 0, $urandom, 0);
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_mdr", mdr_out, 32'hCAFE_F00D);
    access(1, 0, 1, 0, $urandom, 32'h304, $urandom, 2, 32'h5555_AAAA, 0);
    check("sticky_err", {31'd0, err}, 32'd1);
    check("sticky_mdr", mdr_out, 32'h5555_AAAA);

    // Stray ack in IDLE.
    pulse_reset();
    check("clear_err", {31'd0, err}, 32'd0);
    idle(1, 1);
    idle(1, 0);
    check("stray_err", {31'd0, err}, 32'd1);
    check("stray_mdr", mdr_out, 32'd0);
    check("stray_ir",  ir_out,  32'd0);

    // Both strobes: write performed, err raised, data registers untouched.
    pulse_reset();
    access(1, 1, 1, 1, $urandom, 32'h400, 32'hABCD, 2, 32'h7777, 0);
    check("both_we",    {31'd0, bus_we}, 32'd1);
    check("both_err",   {31'd0, err},    32'd1);
    check("both_wdata", bus_wdata, 32'hABCD);
    check("both_ir",    ir_out,  32'd0);
    check("both_mdr",   mdr_out, 32'd0);

    // Randomized traffic; occasional reset keeps err from masking everything.
    pulse_reset();
    for (int i = 0; i < 80; i++) begin
      int op;
      bit rd, wr;
      op = int'($urandom_range(0, 9));
      rd = (op != 1) && (op != 2) && (op != 3);
      wr = (op <= 3);
      if (i % 20 == 19) pulse_reset();
      access(rd, wr, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, TO)), $urandom,
             (op == 9) ? 1 : 0);
      idle(int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0));
    end
    idle(2, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle controller.
- Consumes the controller's MemRead, MemWrite, IorD and IRWrite strobes plus the datapath's PC, ALUOut and store data.
- Runs a req/ack handshake to a variable-latency unified instruction/data memory.
- Holds the fetched word in the IR and the loaded word in the MDR; raises a stall to freeze the controller's state machine until the access completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- TIMEOUT, 255, max cycles in REQ without bus_ack before abort (>=1; counter width = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  controller read strobe.
- mem_write  in  1  controller write strobe.
- ior_d  in  1  address select: 0 = pc, 1 = alu_out.
- ir_write  in  1  read result also loads IR.
- pc  in  ADDR_W  program counter.
- alu_out  in  ADDR_W  data address.
- wr_data  in  DATA_W  store data (rt register B).
- bus_req  out  1  memory request, held until ack.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  registered request address.
- bus_wdata  out  DATA_W  registered write data.
- bus_ack  in  1  memory completion, one-cycle pulse.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- ir_out  out  DATA_W  instruction register.
- mdr_out  out  DATA_W  memory data register.
- stall  out  1  controller hold.
- err  out  1  sticky error flag.

Behaviour:
- States: IDLE, REQ, DONE. Reset (rst=0, async) -> IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ir_out=0, mdr_out=0, err=0, timeout counter=0.
- stall is combinational:
  - 1 in IDLE when mem_read|mem_write.
  - 1 throughout REQ.
  - 0 in DONE and otherwise.
- IDLE:
  - On mem_read|mem_write: latch bus_addr = ior_d ? alu_out : pc, bus_wdata = wr_data, bus_we = mem_write, ir_write into internal ir_pend; clear counter; -> REQ.
  - Both strobes high: write performed, err set.
- REQ:
  - bus_req=1; bus_addr, bus_wdata and bus_we stable.
  - bus_ack sampled high: read loads mdr_out = bus_rdata, and ir_out = bus_rdata if ir_pend; write leaves both unchanged; -> DONE.
  - No ack: counter++. Counter reaching TIMEOUT sets err, leaves registers unchanged, -> DONE.
- DONE:
  - bus_req=0, stall=0; the controller advances at this edge.
  - Strobes ignored this cycle; -> IDLE unconditionally.
- Latency: strobe seen in cycle 0, bus_req from cycle 1. Ack in cycle k gives mdr/ir valid and stall=0 in cycle k+1. Minimum access (ack in cycle 1) stalls 2 cycles.
- bus_ack outside REQ is ignored and sets err.
- err clears only on reset.
- Reset mid-access drops bus_req immediately (async), returns to IDLE, and discards the pending access.
- Addresses passed unmodified; no alignment check; no wrap handling beyond natural ADDR_W truncation.

Test Plan:
- Fetch: ior_d=0, pc=0x40, mem_read=1, ir_write=1; ack in cycle 1 with rdata=0x2008_0005.
  -> bus_addr=0x40, bus_we=0; ir_out=mdr_out=0x2008_0005 in cycle 2; stall high cycles 0-1 only.
- Load with 5-cycle wait: ior_d=1, alu_out=0x100, ir_write=0; ack in cycle 6 with 0xDEAD_BEEF.
  -> mdr_out=0xDEAD_BEEF, ir_out unchanged; stall high cycles 0-6.
- Store: mem_write=1, alu_out=0x204, wr_data=0x1234.
  -> bus_we=1, bus_addr=0x204, bus_wdata=0x1234 held until ack; mdr_out unchanged.
- Timeout with TIMEOUT=4, ack never arrives.
  -> DONE after 4 cycles in REQ; err=1 and stays 1 across the next normal access.
- Reset while in REQ.
  -> bus_req=0 and all outputs at reset values asynchronously; the next request completes normally.
- Both strobes high, plus a stray ack in IDLE.
  -> write issued and err=1; the stray ack changes no data registers.
